mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Memory/IO responder on the CPU's memory port. It is the target side of the MAR/MDR/MEM_EN/WE/R handshake driven by the LC-3 control and datapath.
- Serves word reads and writes to an internal on-chip RAM with a parameterised wait-state latency, and maps one address to I/O: switches on read, hex display register on write.
- Read data is returned on DATA_R, which feeds the datapath's MDR_In.

Parameters:
- AW, 10, RAM address width; the RAM holds 2^AW 16-bit words at addresses 0..2^AW-1.
- LATENCY, 2, wait cycles between request acceptance and the ACK cycle; legal range 0..15.
- IO_ADDR, 16'hFFFF, address of the switch/hex I/O location.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MEM_EN  in  1  request; held high by the CPU until R is seen.
- WE  in  1  1 = write, 0 = read; sampled at acceptance.
- ADDR  in  16  word address, driven from MAR; sampled at acceptance.
- DATA_W  in  16  write data, driven from MDR; sampled at acceptance.
- SW  in  16  switch inputs, returned on reads of IO_ADDR.
- DATA_R  out  16  read data to MDR_In.
- R  out  1  ready/acknowledge; one-cycle pulse.
- HEX_OUT  out  16  display register, written through IO_ADDR.

Behaviour:
- Reset values: R=0, DATA_R=16'h0000, HEX_OUT=16'h0000, FSM in IDLE, wait counter 0. RAM contents are not reset. Reset asserted mid-transaction aborts it: no RAM write, no R pulse.
- States: IDLE, WAIT, ACK, HOLD.
- IDLE: when MEM_EN=1, accept the request by latching ADDR, WE and DATA_W into internal registers. Go to WAIT with counter=LATENCY-1, or straight to ACK if LATENCY=0. Later changes to ADDR, WE or DATA_W have no effect on the accepted request.
- WAIT: decrement the counter each cycle and go to ACK when it is 0. If MEM_EN drops during WAIT, abort to IDLE: no write, no R.
- ACK: R=1 for exactly this cycle, then go to HOLD.
  - Read: DATA_R is registered so it is valid in the ACK cycle. It is held until the next completed read; writes do not change DATA_R.
  - Write: the RAM or HEX_OUT update takes effect at the end of the ACK cycle.
- HOLD: wait for MEM_EN=0, then go to IDLE. Exactly one transaction is served per MEM_EN assertion.
- Timing: request accepted at edge t gives R=1 in the cycle after edge t+LATENCY+1. Total is LATENCY+2 cycles from MEM_EN rising to R.
- Address decode, using the latched address:
  - addr==IO_ADDR: read returns SW as sampled in the ACK-producing cycle; write loads HEX_OUT.
  - addr[15:AW]==0: RAM access.
  - Otherwise: read returns 16'h0000, write is ignored. R is still produced; there is no error signalling.
- RAM: single-port, synchronous read and write. Write-then-read of the same address in back-to-back transactions returns the new data.
- Width rules: RAM index is addr[AW-1:0]. The wait counter is 4 bits.
- R and DATA_R are registered outputs only; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package mem_io_pkg holds:
  - the FSM state enum: IDLE, WAIT, ACK, HOLD;
  - the default IO_ADDR constant;
  - a decode-result enum: DEC_RAM, DEC_IO, DEC_NONE.
- One sub-module: sync_ram (parameter AW, 16-bit data, ports Clk, we, addr, din, dout, with synchronous read). The responder instantiates it and owns all decode and handshake logic.

Test Plan:
- Reset then idle: assert Reset mid-cycle -> R=0, DATA_R=0000, HEX_OUT=0000 immediately, without waiting for a clock edge.
- Write then read RAM, LATENCY=2: write x1234 to ADDR x0005, then read x0005 -> R pulses 4 cycles after each MEM_EN rise, and the read gives DATA_R=x1234.
- I/O: SW=xBEEF, read xFFFF -> DATA_R=xBEEF. Write x00A5 to xFFFF -> HEX_OUT=x00A5 after the ACK edge, and DATA_R stays xBEEF.
- Input stability: change ADDR and DATA_W in WAIT after a write to x0003 is accepted -> only x0003 is written, with the originally sampled data.
- Abort and hold:
  - Drop MEM_EN during WAIT -> no R and RAM unchanged.
  - Hold MEM_EN high for 10 cycles past R -> exactly one R pulse.
- Out-of-range and LATENCY=0: read x0800 with AW=10 -> DATA_R=0000 and R is produced. With LATENCY=0, R comes 2 cycles after MEM_EN rises. Reset asserted in WAIT -> no write, no R.

Source files
------------

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the memory/IO responder.
package mem_io_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Where a latched address lands
    typedef enum logic [1:0] {
        DEC_RAM  = 2'd0,
        DEC_IO   = 2'd1,
        DEC_NONE = 2'd2
    } dec_e;

    // Default location of the switch / hex display I/O word
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/sync_ram.sv
// Single-port 16-bit RAM, synchronous write and synchronous (read-first) read.
// Contents are deliberately not reset.
module sync_ram #(
    parameter int AW = 10
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   din,
    output logic [15:0]   dout
);

    logic [15:0] mem [2**AW];

    // Write when enabled, register the addressed word every cycle
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_io_responder.sv
// Target side of the CPU memory handshake: accepts one request per MEM_EN
// assertion, waits LATENCY cycles, then serves RAM or the switch/hex I/O word
// and pulses R for one cycle. R and DATA_R come straight from registers.
//
// state | meaning
// IDLE  | waiting for MEM_EN; request fields latched on acceptance
// WAIT  | counting down the wait states; MEM_EN low aborts
// ACK   | access performed; R and DATA_R registered at the end of this cycle
// HOLD  | transaction done; wait for MEM_EN to drop
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          AW      = 10,
    parameter int          LATENCY = 2,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_W,
    input  logic [15:0] SW,
    output logic [15:0] DATA_R,
    output logic        R,
    output logic [15:0] HEX_OUT
);

    // LATENCY=0 skips WAIT entirely, so the reload value is only used when LATENCY>0
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic        r_q, r_d;
    logic [15:0] data_r_q, data_r_d;
    logic [15:0] hex_q, hex_d;

    dec_e        dec;
    logic [AW-1:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_dout;

    // Decode the latched address into RAM, I/O or unmapped
    always_comb begin
        dec = DEC_NONE;
        if (addr_q == IO_ADDR) begin
            dec = DEC_IO;
        end else if ((addr_q >> AW) == 16'd0) begin
            dec = DEC_RAM;
        end
    end

    // In IDLE the RAM looks at the live address so that, with LATENCY=0, the
    // read word is already in the RAM output register by the ACK cycle.
    assign ram_addr = (state_q == IDLE) ? ADDR[AW-1:0] : addr_q[AW-1:0];
    assign ram_we   = (state_q == ACK) && we_q && (dec == DEC_RAM);

    sync_ram #(.AW(AW)) u_ram (
        .Clk  (Clk),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    // Next-state, request latching and output register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        r_d      = 1'b0;
        data_r_d = data_r_q;
        hex_d    = hex_q;
        case (state_q)
            IDLE: begin
                if (MEM_EN) begin
                    addr_d  = ADDR;
                    we_d    = WE;
                    wdata_d = DATA_W;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!MEM_EN) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                r_d     = 1'b1;
                state_d = HOLD;
                if (!we_q) begin
                    case (dec)
                        DEC_RAM: data_r_d = ram_dout;
                        DEC_IO:  data_r_d = SW;
                        default: data_r_d = 16'h0000;
                    endcase
                end else if (dec == DEC_IO) begin
                    hex_d = wdata_q;
                end
            end
            HOLD: begin
                if (!MEM_EN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            r_q      <= 1'b0;
            data_r_q <= 16'h0000;
            hex_q    <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            r_q      <= r_d;
            data_r_q <= data_r_d;
            hex_q    <= hex_d;
        end
    end

    assign R       = r_q;
    assign DATA_R  = data_r_q;
    assign HEX_OUT = hex_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench: dut_a runs with LATENCY=2, dut_b with LATENCY=0.
module tb_mem_io_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] ADDR = 16'h0000, DATA_W = 16'h0000, SW = 16'h0000;
    logic [15:0] dr_a, dr_b, hex_a, hex_b;
    logic        r_a, r_b;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          sel;
        logic [15:0] data;
    } sb_t;
    sb_t sb_q[$];

    // Reference model, one per DUT
    logic [15:0] mem_m [2][1024];
    logic [15:0] hex_m [2];
    logic [15:0] dr_m  [2];

    always #5 Clk = ~Clk;

    mem_io_responder #(.AW(10), .LATENCY(2), .IO_ADDR(16'hFFFF)) dut_a (
        .Clk(Clk), .Reset(Reset), .MEM_EN(en_a), .WE(WE), .ADDR(ADDR),
        .DATA_W(DATA_W), .SW(SW), .DATA_R(dr_a), .R(r_a), .HEX_OUT(hex_a)
    );

    mem_io_responder #(.AW(10), .LATENCY(0), .IO_ADDR(16'hFFFF)) dut_b (
        .Clk(Clk), .Reset(Reset), .MEM_EN(en_b), .WE(WE), .ADDR(ADDR),
        .DATA_W(DATA_W), .SW(SW), .DATA_R(dr_b), .R(r_b), .HEX_OUT(hex_b)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_pop(input int sel, input logic rv, input logic [15:0] dr, input logic [15:0] hx);
        sb_t e;
        if (sb_q.size() == 0) begin
            check("r_spurious", {15'd0, rv}, 16'h0000);
        end else begin
            e = sb_q.pop_front();
            check("sb_sel", 16'(sel), 16'(e.sel));
            check("data_r", dr, e.data);
            check("hex_out", hx, hex_m[sel]);
        end
    endtask

    // Every R pulse must match a queued transaction
    always @(negedge Clk) begin
        if (r_a) sb_pop(0, r_a, dr_a, hex_a);
        if (r_b) sb_pop(1, r_b, dr_b, hex_b);
    end

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en_a = v;
        else en_b = v;
    endtask

    function automatic logic get_r(input int sel);
        return (sel == 0) ? r_a : r_b;
    endfunction

    task automatic xact(input int sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input int hold_extra, input bit glitch);
        logic [15:0] v;
        int lat;
        bit seen;
        if (a == 16'hFFFF) begin
            if (w) hex_m[sel] = d;
            v = SW;
        end else if (a[15:10] == 6'd0) begin
            if (w) mem_m[sel][a[9:0]] = d;
            v = mem_m[sel][a[9:0]];
        end else begin
            v = 16'h0000;
        end
        if (!w) dr_m[sel] = v;
        sb_q.push_back('{sel, dr_m[sel]});
        @(negedge Clk);
        WE = w; ADDR = a; DATA_W = d;
        set_en(sel, 1'b1);
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
            if (glitch && lat == 1) begin
                ADDR = 16'h0004;
                DATA_W = 16'hDEAD;
            end
            seen = get_r(sel);
        end
        check(sel == 0 ? "lat_a" : "lat_b", 16'(lat), (sel == 0) ? 16'd4 : 16'd2);
        repeat (hold_extra) @(posedge Clk);
        @(negedge Clk);
        set_en(sel, 1'b0);
        @(posedge Clk);
    endtask

    initial begin
        hex_m[0] = 16'h0; hex_m[1] = 16'h0;
        dr_m[0]  = 16'h0; dr_m[1]  = 16'h0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_r", {15'd0, r_a}, 16'h0000);
        check("rst_data_r", dr_a, 16'h0000);
        check("rst_hex", hex_a, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;

        // RAM write then read
        xact(0, 1'b1, 16'h0005, 16'h1234, 0, 0);
        xact(0, 1'b0, 16'h0005, 16'h0000, 0, 0);

        // I/O read and hex write
        SW = 16'hBEEF;
        xact(0, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
        xact(0, 1'b1, 16'hFFFF, 16'h00A5, 0, 0);
        SW = 16'h1357;

        // Inputs changing after acceptance must not matter
        xact(0, 1'b1, 16'h0004, 16'h1111, 0, 0);
        xact(0, 1'b1, 16'h0003, 16'h5A5A, 0, 1);
        xact(0, 1'b0, 16'h0003, 16'h0000, 0, 0);
        xact(0, 1'b0, 16'h0004, 16'h0000, 0, 0);

        // Abort during WAIT: no R, no write
        @(negedge Clk);
        WE = 1'b1; ADDR = 16'h0003; DATA_W = 16'hBAD0;
        en_a = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        en_a = 1'b0;
        repeat (6) @(posedge Clk);
        xact(0, 1'b0, 16'h0003, 16'h0000, 0, 0);

        // MEM_EN held long past R: one pulse only
        xact(0, 1'b0, 16'h0005, 16'h0000, 10, 0);

        // Unmapped addresses: read gives zero, write does not alias into RAM
        xact(0, 1'b1, 16'h0000, 16'h0101, 0, 0);
        xact(0, 1'b0, 16'h0800, 16'h0000, 0, 0);
        xact(0, 1'b1, 16'h0800, 16'h7777, 0, 0);
        xact(0, 1'b0, 16'h0000, 16'h0000, 0, 0);

        // Zero-latency instance
        xact(1, 1'b1, 16'h0007, 16'h00C3, 0, 0);
        xact(1, 1'b0, 16'h0007, 16'h0000, 0, 0);
        xact(1, 1'b0, 16'hFFFF, 16'h0000, 0, 0);
        xact(0, 1'b0, 16'h3FF, 16'h0000, 0, 0);

        // Reset asserted while in WAIT: outputs clear at once, write dropped
        mem_m[0][1023] = 16'hxxxx;
        @(negedge Clk);
        WE = 1'b1; ADDR = 16'h0003; DATA_W = 16'hFFFF;
        en_a = 1'b1;
        @(posedge Clk);
        #3;
        Reset = 1'b1;
        #1;
        check("mid_rst_r", {15'd0, r_a}, 16'h0000);
        check("mid_rst_data_r", dr_a, 16'h0000);
        check("mid_rst_hex", hex_a, 16'h0000);
        hex_m[0] = 16'h0; hex_m[1] = 16'h0;
        dr_m[0]  = 16'h0; dr_m[1]  = 16'h0;
        @(negedge Clk);
        en_a = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(posedge Clk);
        xact(0, 1'b0, 16'h0003, 16'h0000, 0, 0);

        repeat (4) @(posedge Clk);
        check("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
